// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: decoder controls and operands in, registered
// execute bundle plus stall and bubble count out.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [1:0]        id_reg_dst, id_mem_to_reg;
  logic              id_jump, id_branch, id_bne, id_mem_read, id_mem_write;
  logic              id_alu_src, id_reg_write;
  logic [2:0]        id_alu_op;
  logic [DATA_W-1:0] id_pc4, id_rdata1, id_rdata2, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [5:0]        id_funct;
  logic              flush, ex_hold;

  logic              ex_valid;
  logic [1:0]        ex_reg_dst, ex_mem_to_reg;
  logic              ex_jump, ex_branch, ex_bne, ex_mem_read, ex_mem_write;
  logic              ex_alu_src, ex_reg_write;
  logic [2:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [5:0]        ex_funct;
  logic              stall;
  logic [31:0]       bubble_cnt;

  modport master (
    output id_valid, id_reg_dst, id_mem_to_reg, id_jump, id_branch, id_bne,
           id_mem_read, id_mem_write, id_alu_src, id_reg_write, id_alu_op,
           id_pc4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd, id_funct,
           flush, ex_hold,
    input  ex_valid, ex_reg_dst, ex_mem_to_reg, ex_jump, ex_branch, ex_bne,
           ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
           ex_pc4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
           stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_reg_dst, id_mem_to_reg, id_jump, id_branch, id_bne,
           id_mem_read, id_mem_write, id_alu_src, id_reg_write, id_alu_op,
           id_pc4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd, id_funct,
           flush, ex_hold,
    output ex_valid, ex_reg_dst, ex_mem_to_reg, ex_jump, ex_branch, ex_bne,
           ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
           ex_pc4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
           stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold.
// Define ID_EX_BUBBLE_CNT_EN to build the saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic [1:0]        reg_dst;
        logic [1:0]        mem_to_reg;
        logic              jump, branch, bne, mem_read, mem_write, alu_src, reg_write;
        logic [2:0]        alu_op;
        logic [DATA_W-1:0] pc4, rdata1, rdata2, imm;
        logic [REG_AW-1:0] rs, rt, rd;
        logic [5:0]        funct;
    } bundle_t;

    bundle_t id_b, ex_q, ex_d;
    logic    uses_rs, uses_rt, lu;

    // An invalid decode slot is captured as an all-zero NOP bundle.
    always_comb begin
        id_b = '0;
        if (bus.id_valid) begin
            id_b.valid      = 1'b1;
            id_b.reg_dst    = bus.id_reg_dst;
            id_b.mem_to_reg = bus.id_mem_to_reg;
            id_b.jump       = bus.id_jump;
            id_b.branch     = bus.id_branch;
            id_b.bne        = bus.id_bne;
            id_b.mem_read   = bus.id_mem_read;
            id_b.mem_write  = bus.id_mem_write;
            id_b.alu_src    = bus.id_alu_src;
            id_b.reg_write  = bus.id_reg_write;
            id_b.alu_op     = bus.id_alu_op;
            id_b.pc4        = bus.id_pc4;
            id_b.rdata1     = bus.id_rdata1;
            id_b.rdata2     = bus.id_rdata2;
            id_b.imm        = bus.id_imm;
            id_b.rs         = bus.id_rs;
            id_b.rt         = bus.id_rt;
            id_b.rd         = bus.id_rd;
            id_b.funct      = bus.id_funct;
        end
    end

    assign uses_rs = !bus.id_jump;
    assign uses_rt = (bus.id_reg_dst == 2'b01) | bus.id_mem_write | bus.id_branch | bus.id_bne;

    // $zero destinations never create a dependency.
    assign lu = bus.id_valid & ex_q.valid & ex_q.mem_read & ex_q.reg_write &
                (ex_q.rt != '0) &
                ((uses_rs & (bus.id_rs == ex_q.rt)) | (uses_rt & (bus.id_rt == ex_q.rt)));

    assign bus.stall = (lu & !bus.flush) | bus.ex_hold;

    // Flush beats hold so a killed instruction can never linger in EX.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush || (!bus.ex_hold && lu)) ex_d = '0;
        else if (!bus.ex_hold)                 ex_d = id_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_reg_dst    = ex_q.reg_dst;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_jump       = ex_q.jump;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_bne        = ex_q.bne;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_pc4        = ex_q.pc4;
    assign bus.ex_rdata1     = ex_q.rdata1;
    assign bus.ex_rdata2     = ex_q.rdata2;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_funct      = ex_q.funct;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic        bubble_ld;
    logic [31:0] cnt_q, cnt_d;

    assign bubble_ld = bus.flush | (!bus.ex_hold & lu);

    always_comb begin
        cnt_d = cnt_q;
        if (bubble_ld && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.bubble_cnt = cnt_q;
`else
    assign bus.bubble_cnt = 32'd0;
`endif
endmodule
